ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes the byte stream of the PS/2 receiver (one-cycle `kbs` strobe plus `data` byte) and turns scan-code set 2 sequences into single key events. It handles the `E0` (extended) and `F0` (break) prefixes, the 8-byte `E1` Pause sequence, and a prefix timeout. It tracks Shift/Ctrl/Alt state. Decoded events are buffered in a small FIFO with a valid/ready handshake for the application logic downstream.

## Interface
- `TIMEOUT`, 200000: idle clock cycles after a prefix byte before the partial sequence is abandoned.
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW entries.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `kbs` in 1: one-cycle strobe; `data` is a new valid byte.
- `data` in 8: received byte; sampled only when `kbs`=1.
- `parity_error` in 1: receiver parity-error level.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_valid` out 1: FIFO non-empty.
- `ev_code` out 8: head event key code.
- `ev_ext` out 1: head event is extended (E0-prefixed).
- `ev_break` out 1: head event is a key release.
- `mod_shift` out 1: left or right Shift held.
- `mod_ctrl` out 1: left or right Ctrl held.
- `mod_alt` out 1: left or right Alt held.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.

## Operation
- FSM states:
  - IDLE
  - EXT (E0 seen)
  - BRK (F0 seen)
  - EXT_BRK (E0 F0 seen)
  - PAUSE (E1 seen, skipping)
- Transitions apply only on `kbs`=1 with `parity_error`=0.
- IDLE:
  - `E0` goes to EXT; `F0` goes to BRK.
  - `E1` goes to PAUSE with skip counter = 7.
  - `AA`, `FA`, `EE`, `FE`, `00`, `FF` are discarded; stay in IDLE.
  - Any other byte emits {ext=0, brk=0, code}.
- EXT: `F0` goes to EXT_BRK. Any other byte emits {1, 0, code} and goes to IDLE.
- BRK: any byte emits {0, 1, code} and goes to IDLE.
- EXT_BRK: any byte emits {1, 1, code} and goes to IDLE.
- PAUSE:
  - Each `kbs` decrements the skip counter.
  - On the byte that brings it to 0, emit {0, 0, `E1`} and go to IDLE.
  - No break event is ever produced for Pause.
- Modifier tracking, updated on every decode, whether or not the FIFO accepts the event:
  - Make sets the bit; break clears it.
  - Codes: L-Shift `12`, R-Shift `59` (non-ext), L-Ctrl `14`, R-Ctrl E0 `14`, L-Alt `11`, R-Alt E0 `11`.
  - Extended `12` (fake shift) is ignored for modifier tracking but still emitted.
  - `mod_*` = OR of left and right.
- Timeout:
  - Counter clears on every `kbs`.
  - It counts only in EXT, BRK, EXT_BRK and PAUSE.
  - Reaching `TIMEOUT` returns the FSM to IDLE; nothing is emitted.
- A rising edge of `parity_error` returns the FSM to IDLE from any state. A `kbs` that coincides with `parity_error`=1 is ignored.
- FIFO:
  - Entry = {ext, brk, code}, 10 bits.
  - First-word-fall-through; outputs show the head entry.
  - Pop when `ev_valid` & `ev_ready`.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and sets `overflow`.
  - A push and pop in the same cycle when full both succeed; count is unchanged and `overflow` is not set.
- Empty FIFO: `ev_ready` has no effect. Pointers wrap modulo 2^FIFO_AW.

## Timing
- Reset:
  - FSM = IDLE; counters = 0; FIFO empty.
  - `ev_valid`=0; `ev_code`=00; `ev_ext`=0; `ev_break`=0.
  - `mod_*`=0; `overflow`=0.
- A `kbs` at the edge ending cycle N writes the event. With the FIFO empty, `ev_valid`=1 during cycle N+1 (1-cycle latency).
- Modifier outputs change in cycle N+1.
- Pop at an edge: the next entry, or `ev_valid`=0, appears the following cycle.
- `kbs` strobes back-to-back on consecutive cycles must be handled; the FSM is one byte per cycle.
- Timeout fires on the cycle the counter equals `TIMEOUT`; the state is IDLE the next cycle.
- Reset asserted mid-sequence or with the FIFO partly full clears everything immediately.

## Test plan
- Bytes `1C`, `F0`, `1C` with `ev_ready`=1 give two events: {0,0,1C} then {0,1,1C}, each with a 1-cycle `ev_valid` pulse after its final byte.
- Bytes `E0 75`, `E0 F0 75` give {1,0,75} and {1,1,75}. `E0 14` gives `mod_ctrl`=1. `E0 F0 14` gives `mod_ctrl`=0.
- Bytes `E1 14 77 E1 F0 14 F0 77` give exactly one event {0,0,E1} after the 8th byte. `mod_ctrl` stays 0 throughout.
- Hold `ev_ready`=0 and send 5 make codes `15 16 17 18 19` with FIFO_AW=2:
  - `overflow`=1 after the 5th code.
  - Draining yields `15 16 17 18`, then `ev_valid`=0.
- Send `F0`, wait `TIMEOUT` cycles, then send `1C`. The result is {0,0,1C}, not a break.
- Send `E0`, pulse `parity_error`, then send `1C`. The result is {0,0,1C}. `AA`/`FA` sent in IDLE produce no event.

Source files
------------

// File: rtl/ps2_ev_if.sv
// Key-event handshake between the scan-code decoder and its consumer.
interface ps2_ev_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_break,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_break,
        output ev_ready
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Turns PS/2 scan-code set 2 byte sequences into key events, tracks Shift/Ctrl/Alt,
// and buffers events in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT = 200000,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbs,
    input  logic [7:0] data,
    input  logic       parity_error,
    ps2_ev_if.master   ev,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       overflow
);

    localparam int unsigned CntTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned CntW  = FIFO_AW + 1;

    localparam logic [CntTW-1:0]   TimeoutVal = CntTW'(TIMEOUT);
    localparam logic [CntTW-1:0]   TOne       = CntTW'(1);
    localparam logic [FIFO_AW-1:0] PtrOne     = FIFO_AW'(1);
    localparam logic [CntW-1:0]    CntOne     = CntW'(1);
    localparam logic [CntW-1:0]    CntFull    = CntW'(Depth);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

    state_e             state_q, state_d;
    logic [2:0]         skip_q, skip_d;
    logic [CntTW-1:0]   tcnt_q, tcnt_d;
    logic               pe_q;
    logic [5:0]         mod_q, mod_d;  // lshift, rshift, lctrl, rctrl, lalt, ralt
    logic               ovf_q;

    logic               byte_ok, pe_rise;
    logic               emit, em_ext, em_brk;
    logic [7:0]         em_code;

    logic [9:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic               valid, full, pop, push_ok;

    assign byte_ok = kbs & ~parity_error;
    assign pe_rise = parity_error & ~pe_q;

    // Sequence decoder: next state, timeout counter and event emission.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tcnt_d  = tcnt_q;
        emit    = 1'b0;
        em_ext  = 1'b0;
        em_brk  = 1'b0;
        em_code = data;
        if (pe_rise) begin
            state_d = StIdle;
            tcnt_d  = '0;
            skip_d  = '0;
        end else if (byte_ok) begin
            tcnt_d = '0;
            case (state_q)
                StIdle: begin
                    case (data)
                        8'hE0: state_d = StExt;
                        8'hF0: state_d = StBrk;
                        8'hE1: begin
                            state_d = StPause;
                            skip_d  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: emit = 1'b1;
                    endcase
                end
                StExt: begin
                    if (data == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        emit    = 1'b1;
                        em_ext  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    emit    = 1'b1;
                    em_brk  = 1'b1;
                    state_d = StIdle;
                end
                StExtBrk: begin
                    emit    = 1'b1;
                    em_ext  = 1'b1;
                    em_brk  = 1'b1;
                    state_d = StIdle;
                end
                StPause: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        emit    = 1'b1;
                        em_code = 8'hE1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // A partial sequence left idle too long is abandoned silently.
            if (tcnt_q == TimeoutVal) begin
                state_d = StIdle;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + TOne;
            end
        end
    end

    // Modifier tracking follows every decoded event, even one the FIFO drops.
    always_comb begin
        mod_d = mod_q;
        if (emit) begin
            case ({em_ext, em_code})
                9'h012:  mod_d[0] = ~em_brk;
                9'h059:  mod_d[1] = ~em_brk;
                9'h014:  mod_d[2] = ~em_brk;
                9'h114:  mod_d[3] = ~em_brk;
                9'h011:  mod_d[4] = ~em_brk;
                9'h111:  mod_d[5] = ~em_brk;
                default: ;
            endcase
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        valid   = (count_q != '0);
        full    = (count_q == CntFull);
        pop     = valid & ev.ev_ready;
        push_ok = emit & (~full | pop);
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: ;
        endcase
    end

    // Decoder, modifier and FIFO pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            skip_q   <= '0;
            tcnt_q   <= '0;
            pe_q     <= 1'b0;
            mod_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tcnt_q  <= tcnt_d;
            pe_q    <= parity_error;
            mod_q   <= mod_d;
            count_q <= count_d;
            if (emit && !push_ok) ovf_q <= 1'b1;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Event storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {em_ext, em_brk, em_code};
    end

    // Head-of-FIFO and status outputs; the head reads as zero while empty.
    always_comb begin
        ev.ev_valid = valid;
        {ev.ev_ext, ev.ev_break, ev.ev_code} = valid ? mem_q[rd_ptr_q] : 10'h000;
        mod_shift = mod_q[0] | mod_q[1];
        mod_ctrl  = mod_q[2] | mod_q[3];
        mod_alt   = mod_q[4] | mod_q[5];
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized bench for ps2_scancode_decoder with a queue-based reference model.
module tb_ps2_scancode_decoder;

    localparam int unsigned TO    = 24;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       rst;
    logic       kbs;
    logic [7:0] data;
    logic       parity_error;
    logic       mod_shift, mod_ctrl, mod_alt, overflow;

    ps2_ev_if ev_if ();

    ps2_scancode_decoder #(
        .TIMEOUT (TO),
        .FIFO_AW (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kbs          (kbs),
        .data         (data),
        .parity_error (parity_error),
        .ev           (ev_if),
        .mod_shift    (mod_shift),
        .mod_ctrl     (mod_ctrl),
        .mod_alt      (mod_alt),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    bit rnd    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prefix flags, pending Pause byte count, event queue, held keys.
    bit         m_ext, m_brk, pe_prev, m_ovf;
    int         m_pause;
    longint     cyc, last_cyc;
    logic [9:0] q[$];
    bit         held [512];

    function automatic bit is_mod(input logic [8:0] k);
        return k inside {9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111};
    endfunction

    always @(posedge clk or posedge rst) begin
        bit         pend, pop, emit, ok;
        logic [9:0] evn;
        if (rst) begin
            m_ext = 0; m_brk = 0; m_pause = 0; pe_prev = 0; m_ovf = 0;
            cyc = 0; last_cyc = 0;
            q.delete();
            for (int i = 0; i < 512; i++) held[i] = 0;
        end else begin
            pend = m_ext | m_brk | (m_pause != 0);
            emit = 0;
            evn  = '0;
            if (parity_error && !pe_prev) begin
                m_ext = 0; m_brk = 0; m_pause = 0;
            end else if (kbs && !parity_error) begin
                last_cyc = cyc;
                if (m_pause > 0) begin
                    m_pause--;
                    if (m_pause == 0) begin emit = 1; evn = {2'b00, 8'hE1}; end
                end else if (!m_ext && !m_brk) begin
                    if (data == 8'hE0) m_ext = 1;
                    else if (data == 8'hF0) m_brk = 1;
                    else if (data == 8'hE1) m_pause = 7;
                    else if (!(data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                        emit = 1; evn = {2'b00, data};
                    end
                end else if (m_ext && !m_brk && data == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    emit = 1; evn = {m_ext, m_brk, data};
                    m_ext = 0; m_brk = 0;
                end
            end else if (pend && (cyc - last_cyc) >= longint'(TO + 1)) begin
                m_ext = 0; m_brk = 0; m_pause = 0;
            end
            pe_prev = parity_error;
            pop = (q.size() > 0) && ev_if.ev_ready;
            ok  = 0;
            if (emit) begin
                if (is_mod({evn[9], evn[7:0]}) && evn != {2'b00, 8'hE1})
                    held[{evn[9], evn[7:0]}] = !evn[8];
                ok = (q.size() < DEPTH) || pop;
                if (!ok) m_ovf = 1;
            end
            if (pop) void'(q.pop_front());
            if (ok) q.push_back(evn);
            cyc++;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ev_valid", ev_if.ev_valid, q.size() != 0);
            if (q.size() != 0) chk("head", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, q[0]);
            chk("mods", {mod_shift, mod_ctrl, mod_alt},
                {held[9'h012] | held[9'h059], held[9'h014] | held[9'h114],
                 held[9'h011] | held[9'h111]});
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd) ev_if.ev_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one byte for exactly one cycle; returns at the start of the next cycle.
    task automatic put(input logic [7:0] b);
        kbs  = 1'b1;
        data = b;
        @(posedge clk);
        #1;
        kbs = 1'b0;
    endtask

    task automatic expect_ev(input logic [7:0] c, input bit e, input bit b);
        @(negedge clk);
        chk("lit_valid", ev_if.ev_valid, 1'b1);
        chk("lit_event", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, {e, b, c});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lit_pulse_end", ev_if.ev_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic neg_chk(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        @(negedge clk);
        case (act_sel)
            0: chk(name, ev_if.ev_valid, exp);
            1: chk(name, mod_ctrl, exp);
            2: chk(name, overflow, exp);
            default: chk(name, ev_if.ev_code, exp);
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mods [4];
        logic [7:0] b;
        int         r, g;
        mods = '{8'h12, 8'h59, 8'h14, 8'h11};
        rst = 1'b1; kbs = 1'b0; data = 8'h00; parity_error = 1'b0; ev_if.ev_ready = 1'b1;
        #1 cmp_en = 1;
        @(negedge clk);
        chk("reset_state", {ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code,
                            mod_shift, mod_ctrl, mod_alt, overflow}, '0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        put(8'h1C); expect_ev(8'h1C, 0, 0);
        put(8'hF0); put(8'h1C); expect_ev(8'h1C, 0, 1);
        put(8'hE0); put(8'h75); expect_ev(8'h75, 1, 0);
        put(8'hE0); put(8'hF0); put(8'h75); expect_ev(8'h75, 1, 1);
        put(8'hE0); put(8'h14); expect_ev(8'h14, 1, 0);
        neg_chk("rctrl_make", 1, 1);
        put(8'hE0); put(8'hF0); put(8'h14); expect_ev(8'h14, 1, 1);
        neg_chk("rctrl_break", 1, 0);

        put(8'hE1); put(8'h14); put(8'h77); put(8'hE1); put(8'hF0); put(8'h14); put(8'hF0);
        neg_chk("pause_no_event", 0, 0);
        neg_chk("pause_no_ctrl", 1, 0);
        put(8'h77); expect_ev(8'hE1, 0, 0);

        ev_if.ev_ready = 1'b0;
        put(8'h15); put(8'h16); put(8'h17); put(8'h18);
        neg_chk("ovf_before", 2, 0);
        put(8'h19);
        neg_chk("ovf_after", 2, 1);
        ev_if.ev_ready = 1'b1;
        neg_chk("drain0", 3, 8'h15);
        neg_chk("drain1", 3, 8'h16);
        neg_chk("drain2", 3, 8'h17);
        neg_chk("drain3", 3, 8'h18);
        neg_chk("drain_empty", 0, 0);

        ev_if.ev_ready = 1'b0;
        put(8'h21); put(8'h22); put(8'hE0);
        rst = 1'b1;
        #2;
        chk("async_rst", {ev_if.ev_valid, overflow}, 2'b00);
        @(posedge clk); #1 rst = 1'b0;
        ev_if.ev_ready = 1'b1;
        idle(1);

        put(8'hF0); idle(TO + 2); put(8'h1C); expect_ev(8'h1C, 0, 0);
        put(8'hF0); idle(TO - 2); put(8'h1C); expect_ev(8'h1C, 0, 1);

        put(8'hE0); parity_error = 1'b1; idle(1); parity_error = 1'b0;
        put(8'h1C); expect_ev(8'h1C, 0, 0);
        parity_error = 1'b1; put(8'h2C); parity_error = 1'b0;
        neg_chk("parity_drop", 0, 0);
        put(8'hAA); put(8'hFA);
        neg_chk("discard", 0, 0);

        rnd = 1;
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      b = 8'hE0;
            else if (r < 19) b = 8'hF0;
            else if (r < 22) b = 8'hE1;
            else if (r < 45) b = mods[$urandom_range(0, 3)];
            else if (r < 50) b = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA;
            else             b = 8'($urandom_range(0, 255));
            ev_if.ev_ready = ($urandom_range(0, 2) != 0);
            parity_error = ($urandom_range(0, 39) == 0);
            put(b);
            parity_error = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                g = $urandom_range(TO - 3, TO + 3);
                if (g == TO) g = TO + 1;
            end else begin
                g = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 49) == 0) begin
                parity_error = 1'b1; idle(1); parity_error = 1'b0;
            end
            idle(g);
        end
        rnd = 0;
        ev_if.ev_ready = 1'b1;
        idle(DEPTH + 2);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
